// File: rtl/easyaxi_ost_pkg.sv
// Shared slot-state encodings and width helpers for the outstanding-slot allocator.
package easyaxi_ost_pkg;

    typedef enum logic [1:0] {
        SlotFree   = 2'b00,
        SlotActive = 2'b01,
        SlotResp   = 2'b10
    } slot_state_e;

    function automatic int unsigned ptr_width(int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/easyaxi_prio_enc.sv
// Lowest-set-bit finder: returns the index of the lowest set request bit and a found flag.
module easyaxi_prio_enc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]         req_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     found_o
);

    localparam int unsigned IdxW = $clog2(WIDTH);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IdxW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/easyaxi_ost_alloc.sv
// Outstanding-slot allocator: grants the lowest free slot, stores its ID, frees it on the last beat.
// Optional EASYAXI_OST_CHK_EN adds a sticky ost_err_o for FREE-slot responses and overflow attempts.
module easyaxi_ost_alloc
    import easyaxi_ost_pkg::*;
#(
    parameter int unsigned OST_DEPTH = 16,
    parameter int unsigned ID_WIDTH  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            alloc_req_i,
    input  logic [ID_WIDTH-1:0]             alloc_id_i,
    output logic                            alloc_gnt_o,
    output logic [ptr_width(OST_DEPTH)-1:0] alloc_ptr_o,
    input  logic                            resp_i,
    input  logic [ptr_width(OST_DEPTH)-1:0] resp_ptr_i,
    input  logic                            resp_last_i,
    output logic [ID_WIDTH-1:0]             resp_id_o,
    output logic [OST_DEPTH-1:0]            slot_busy_o,
    output logic [OST_DEPTH-1:0]            slot_inresp_o,
    output logic [cnt_width(OST_DEPTH)-1:0] ost_cnt_o,
    output logic                            ost_full_o,
    output logic                            ost_empty_o
`ifdef EASYAXI_OST_CHK_EN
    ,
    output logic                            ost_err_o
`endif
);

    localparam int unsigned PtrW = ptr_width(OST_DEPTH);
    localparam int unsigned CntW = cnt_width(OST_DEPTH);

    slot_state_e               state_q [OST_DEPTH];
    slot_state_e               state_d [OST_DEPTH];
    logic        [ID_WIDTH-1:0] id_q   [OST_DEPTH];
    logic        [ID_WIDTH-1:0] id_d   [OST_DEPTH];
    logic        [CntW-1:0]     cnt_q, cnt_d;

    logic [PtrW-1:0] free_idx;
    logic            free_found;
    logic            cnt_inc, cnt_dec;
    logic            resp_to_free;

    always_comb begin
        for (int i = 0; i < OST_DEPTH; i++) begin
            slot_busy_o[i]   = (state_q[i] != SlotFree);
            slot_inresp_o[i] = (state_q[i] == SlotResp);
        end
    end

    easyaxi_prio_enc #(
        .WIDTH (OST_DEPTH)
    ) u_prio_enc (
        .req_i   (~slot_busy_o),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    // A slot freed this cycle is still busy here, so it cannot be re-granted until next cycle.
    assign ost_full_o  = ~free_found;
    assign alloc_gnt_o = alloc_req_i & free_found;
    assign alloc_ptr_o = free_found ? free_idx : '0;
    assign ost_empty_o = (cnt_q == '0);
    assign ost_cnt_o   = cnt_q;
    assign resp_id_o   = id_q[resp_ptr_i];

    assign resp_to_free = resp_i & (state_q[resp_ptr_i] == SlotFree);
    assign cnt_inc      = alloc_gnt_o;
    assign cnt_dec      = resp_i & resp_last_i & ~resp_to_free;

    always_comb begin
        for (int i = 0; i < OST_DEPTH; i++) begin
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            unique case (state_q[i])
                SlotFree: begin
                    if (alloc_gnt_o && (alloc_ptr_o == PtrW'(i))) begin
                        state_d[i] = SlotActive;
                        id_d[i]    = alloc_id_i;
                    end
                end
                SlotActive, SlotResp: begin
                    if (resp_i && (resp_ptr_i == PtrW'(i))) begin
                        state_d[i] = resp_last_i ? SlotFree : SlotResp;
                    end
                end
                default: state_d[i] = SlotFree;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < OST_DEPTH; i++) begin
                state_q[i] <= SlotFree;
                id_q[i]    <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < OST_DEPTH; i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

`ifdef EASYAXI_OST_CHK_EN
    logic err_q, err_d;

    assign err_d     = err_q | resp_to_free | (alloc_req_i & ost_full_o);
    assign ost_err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_easyaxi_ost_alloc.sv
// Scoreboard bench for easyaxi_ost_alloc: stimulus queues expectations, a negedge monitor checks them.
module tb_easyaxi_ost_alloc;

    localparam int unsigned Depth = 16;
    localparam int unsigned IdW   = 4;
    localparam int unsigned PtrW  = 4;
    localparam int unsigned CntW  = 5;

    localparam int SelCnt    = 0;
    localparam int SelFull   = 1;
    localparam int SelEmpty  = 2;
    localparam int SelBusy   = 3;
    localparam int SelInresp = 4;
    localparam int SelPtr    = 5;
    localparam int SelGnt    = 6;
    localparam int SelRespId = 7;
    localparam int SelErr    = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic            clk;
    logic            rst_n;
    logic            alloc_req;
    logic [IdW-1:0]  alloc_id;
    logic            alloc_gnt;
    logic [PtrW-1:0] alloc_ptr;
    logic            resp;
    logic [PtrW-1:0] resp_ptr;
    logic            resp_last;
    logic [IdW-1:0]  resp_id;
    logic [Depth-1:0] slot_busy;
    logic [Depth-1:0] slot_inresp;
    logic [CntW-1:0] ost_cnt;
    logic            ost_full;
    logic            ost_empty;
    logic            ost_err;

    chk_t chk_q[$];
    int   gnt_q[$];
    int   total  = 0;
    int   passed = 0;

    easyaxi_ost_alloc #(
        .OST_DEPTH (Depth),
        .ID_WIDTH  (IdW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .alloc_req_i   (alloc_req),
        .alloc_id_i    (alloc_id),
        .alloc_gnt_o   (alloc_gnt),
        .alloc_ptr_o   (alloc_ptr),
        .resp_i        (resp),
        .resp_ptr_i    (resp_ptr),
        .resp_last_i   (resp_last),
        .resp_id_o     (resp_id),
        .slot_busy_o   (slot_busy),
        .slot_inresp_o (slot_inresp),
        .ost_cnt_o     (ost_cnt),
        .ost_full_o    (ost_full),
        .ost_empty_o   (ost_empty)
`ifdef EASYAXI_OST_CHK_EN
        ,
        .ost_err_o     (ost_err)
`endif
    );

`ifndef EASYAXI_OST_CHK_EN
    assign ost_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sel_val(int sel);
        case (sel)
            SelCnt:    return 32'(ost_cnt);
            SelFull:   return 32'(ost_full);
            SelEmpty:  return 32'(ost_empty);
            SelBusy:   return 32'(slot_busy);
            SelInresp: return 32'(slot_inresp);
            SelPtr:    return 32'(alloc_ptr);
            SelGnt:    return 32'(alloc_gnt);
            SelRespId: return 32'(resp_id);
            default:   return 32'(ost_err);
        endcase
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: grants are matched against the grant queue, queued checks are drained each cycle.
    always @(negedge clk) begin
        if (alloc_gnt === 1'b1) begin
            if (gnt_q.size() == 0) begin
                compare("unexpected_grant_ptr", 32'(alloc_ptr), 32'hFFFF_FFFF);
            end else begin
                compare("grant_ptr", 32'(alloc_ptr), 32'(gnt_q.pop_front()));
            end
        end
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            compare(c.name, sel_val(c.sel), c.exp);
        end
    end

    task automatic expect_sig(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_err(input string name, input logic exp);
`ifdef EASYAXI_OST_CHK_EN
        expect_sig(name, SelErr, 32'(exp));
`else
        if (exp !== 1'bx) begin
        end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0;
        alloc_id  = '0;
        resp      = 1'b0;
        resp_ptr  = '0;
        resp_last = 1'b0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_sig({tag, "_cnt"}, SelCnt, 32'd0);
        expect_sig({tag, "_empty"}, SelEmpty, 32'd1);
        expect_sig({tag, "_full"}, SelFull, 32'd0);
        expect_sig({tag, "_busy"}, SelBusy, 32'd0);
        expect_sig({tag, "_inresp"}, SelInresp, 32'd0);
        expect_sig({tag, "_ptr"}, SelPtr, 32'd0);
        expect_sig({tag, "_gnt"}, SelGnt, 32'd0);
        expect_err({tag, "_err"}, 1'b0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_ptr = 4'd1;
        expect_reset_state("reset");
        expect_sig("reset_resp_id", SelRespId, 32'd0);
        step();

        // Three back-to-back grants
        alloc_req = 1'b1; alloc_id = 4'd5; gnt_q.push_back(0); step();
        alloc_id = 4'd5; gnt_q.push_back(1); step();
        alloc_id = 4'd2; gnt_q.push_back(2); step();
        idle(); resp_ptr = 4'd1;
        expect_sig("three_cnt", SelCnt, 32'd3);
        expect_sig("three_busy", SelBusy, 32'h0007);
        expect_sig("slot1_id", SelRespId, 32'd5);
        expect_sig("three_empty", SelEmpty, 32'd0);
        step();

        // Multi-beat response on slot 1
        resp = 1'b1; resp_ptr = 4'd1; resp_last = 1'b0; step();
        expect_sig("beat1_inresp", SelInresp, 32'h0002); step();
        resp_last = 1'b1;
        expect_sig("beat2_inresp", SelInresp, 32'h0002); step();
        idle();
        expect_sig("freed_inresp", SelInresp, 32'h0000);
        expect_sig("freed_busy", SelBusy, 32'h0005);
        expect_sig("freed_cnt", SelCnt, 32'd2);
        alloc_req = 1'b1; alloc_id = 4'd7; gnt_q.push_back(1); step();
        idle();
        expect_sig("regrant_cnt", SelCnt, 32'd3);
        expect_sig("regrant_busy", SelBusy, 32'h0007);
        step();

        // Fill remaining slots
        for (int i = 3; i < 16; i++) begin
            alloc_req = 1'b1; alloc_id = IdW'(i); gnt_q.push_back(i); step();
        end
        alloc_req = 1'b1; alloc_id = 4'd1;
        expect_sig("full_gnt", SelGnt, 32'd0);
        expect_sig("full_flag", SelFull, 32'd1);
        expect_sig("full_ptr", SelPtr, 32'd0);
        expect_sig("full_cnt", SelCnt, 32'd16);
        expect_sig("full_busy", SelBusy, 32'hFFFF);
        step();

        // Free slot 7 while requesting: no bypass
        resp = 1'b1; resp_ptr = 4'd7; resp_last = 1'b1;
        expect_sig("nobypass_gnt", SelGnt, 32'd0);
        expect_err("overflow_err", 1'b1);
        step();
        resp = 1'b0;
        gnt_q.push_back(7);
        expect_sig("after_free_cnt", SelCnt, 32'd15);
        expect_sig("after_free_full", SelFull, 32'd0);
        step();
        idle();
        expect_sig("refill_cnt", SelCnt, 32'd16);
        expect_sig("refill_full", SelFull, 32'd1);
        step();

        // Grant and free of another slot in the same cycle
        resp = 1'b1; resp_ptr = 4'd4; resp_last = 1'b1; step();
        idle();
        expect_sig("free4_cnt", SelCnt, 32'd15);
        expect_sig("free4_busy", SelBusy, 32'hFFEF);
        alloc_req = 1'b1; alloc_id = 4'd3; gnt_q.push_back(4);
        resp = 1'b1; resp_ptr = 4'd9; resp_last = 1'b1;
        step();
        idle();
        expect_sig("concurrent_cnt", SelCnt, 32'd15);
        expect_sig("concurrent_busy", SelBusy, 32'hFDFF);
        step();

        // Async reset mid-stream, checked before any further rising edge
        rst_n = 1'b0;
        resp_ptr = 4'd2;
        expect_reset_state("async1");
        expect_sig("async1_resp_id", SelRespId, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1; alloc_id = IdW'(i + 1); gnt_q.push_back(i); step();
        end
        idle();
        resp = 1'b1; resp_ptr = 4'd12; resp_last = 1'b1; step();
        idle(); resp_ptr = 4'd2;
        expect_sig("freeslot_cnt", SelCnt, 32'd4);
        expect_sig("freeslot_busy", SelBusy, 32'h000F);
        expect_sig("slot2_id", SelRespId, 32'd3);
        expect_err("freeslot_err", 1'b1);
        step();

        rst_n = 1'b0;
        expect_reset_state("async2");
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        #1;

        while (gnt_q.size() > 0) begin
            compare("missing_grant_ptr", 32'hFFFF_FFFF, 32'(gnt_q.pop_front()));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
